// File: rtl/hilo_unit_pkg.sv
// Shared constants and state encoding for the HI/LO register pair
// and its iterative divider.
package hilo_unit_pkg;

    localparam int LENGTH    = 32;
    localparam int DIV_ITERS = 32;
    localparam int ITER_W    = $clog2(DIV_ITERS);

    typedef enum logic [1:0] {
        HILO_IDLE   = 2'd0,
        HILO_CALC   = 2'd1,
        HILO_FINISH = 2'd2
    } hilo_state_t;

endpackage

// File: rtl/hilo_unit_div_iter.sv
// Radix-2 restoring divider datapath: magnitude load, shift/subtract
// step, and sign fix-up of quotient and remainder.
module hilo_unit_div_iter
    import hilo_unit_pkg::*;
#(
    parameter int WIDTH = LENGTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem
);

    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   dvsr;
    logic [WIDTH-1:0]   a_raw;
    logic               sign_q;
    logic               sign_r;
    logic               b_zero;

    logic               neg_a;
    logic               neg_b;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [2*WIDTH-1:0] sh;
    logic [WIDTH:0]     diff;
    logic [WIDTH-1:0]   q_raw;
    logic [WIDTH-1:0]   r_raw;

    assign neg_a = is_signed & a[WIDTH-1];
    assign neg_b = is_signed & b[WIDTH-1];
    assign mag_a = neg_a ? -a : a;
    assign mag_b = neg_b ? -b : b;

    assign sh   = {acc[2*WIDTH-2:0], 1'b0};
    assign diff = {1'b0, sh[2*WIDTH-1:WIDTH]} - {1'b0, dvsr};

    assign q_raw = acc[WIDTH-1:0];
    assign r_raw = acc[2*WIDTH-1:WIDTH];

    // Zero divisor overrides the raw result; the iterations still run.
    assign quot = b_zero ? '1 : (sign_q ? -q_raw : q_raw);
    assign rem  = b_zero ? a_raw : (sign_r ? -r_raw : r_raw);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            dvsr   <= '0;
            a_raw  <= '0;
            sign_q <= 1'b0;
            sign_r <= 1'b0;
            b_zero <= 1'b0;
        end else if (load) begin
            acc    <= {{WIDTH{1'b0}}, mag_a};
            dvsr   <= mag_b;
            a_raw  <= a;
            sign_q <= neg_a ^ neg_b;
            sign_r <= neg_a;
            b_zero <= (b == '0);
        end else if (step) begin
            if (!diff[WIDTH]) begin
                acc <= {diff[WIDTH-1:0], sh[WIDTH-1:1], 1'b1};
            end else begin
                acc <= sh;
            end
        end
    end

endmodule

// File: rtl/hilo_unit.sv
// Architectural HI/LO registers with ALU write port and a
// multi-cycle DIV/DIVU engine that stalls the pipeline.
module hilo_unit
    import hilo_unit_pkg::*;
#(
    parameter int WIDTH = LENGTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             w_hilo,
    input  logic [WIDTH-1:0] write_hi,
    input  logic [WIDTH-1:0] write_lo,
    input  logic             div_start,
    input  logic             div_signed,
    input  logic [WIDTH-1:0] div_a,
    input  logic [WIDTH-1:0] div_b,
    output logic             stall,
    output logic             div_done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    hilo_state_t       state;
    hilo_state_t       state_nx;
    logic [ITER_W-1:0] iter;
    logic              load;
    logic              step;
    logic              last;
    logic              idle;
    logic [WIDTH-1:0]  quot;
    logic [WIDTH-1:0]  rem;

    assign idle     = (state == HILO_IDLE);
    assign last     = (iter == ITER_W'(DIV_ITERS - 1));
    assign stall    = !idle | div_start;
    assign div_done = (state == HILO_FINISH);

    always_comb begin
        state_nx = state;
        load     = 1'b0;
        step     = 1'b0;
        case (state)
            HILO_IDLE: begin
                if (div_start) begin
                    load     = 1'b1;
                    state_nx = HILO_CALC;
                end
            end
            HILO_CALC: begin
                step = 1'b1;
                if (last) begin
                    state_nx = HILO_FINISH;
                end
            end
            HILO_FINISH: state_nx = HILO_IDLE;
            default:     state_nx = HILO_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= HILO_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iter <= '0;
        end else if (load) begin
            iter <= '0;
        end else if (step) begin
            iter <= iter + 1'b1;
        end
    end

    // ALU writes only land in IDLE; FINISH always wins over them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi <= '0;
            lo <= '0;
        end else if (div_done) begin
            hi <= rem;
            lo <= quot;
        end else if (idle && w_hilo) begin
            hi <= write_hi;
            lo <= write_lo;
        end
    end

    hilo_unit_div_iter #(
        .WIDTH(WIDTH)
    ) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .step     (step),
        .is_signed(div_signed),
        .a        (div_a),
        .b        (div_b),
        .quot     (quot),
        .rem      (rem)
    );

endmodule

// File: tb/tb_hilo_unit.sv
// Randomised bench for hilo_unit against an arithmetic HI/LO model.
module tb_hilo_unit;

    logic        clk;
    logic        rst_n;
    logic        w_hilo;
    logic [31:0] write_hi;
    logic [31:0] write_lo;
    logic        div_start;
    logic        div_signed;
    logic [31:0] div_a;
    logic [31:0] div_b;
    logic        stall;
    logic        div_done;
    logic [31:0] hi;
    logic [31:0] lo;

    int          total;
    int          bad;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;

    hilo_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .w_hilo    (w_hilo),
        .write_hi  (write_hi),
        .write_lo  (write_lo),
        .div_start (div_start),
        .div_signed(div_signed),
        .div_a     (div_a),
        .div_b     (div_b),
        .stall     (stall),
        .div_done  (div_done),
        .hi        (hi),
        .lo        (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    function automatic void model(input logic sgn, input logic [31:0] a,
                                  input logic [31:0] b,
                                  output logic [31:0] q,
                                  output logic [31:0] r);
        longint x;
        longint y;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else begin
            if (sgn) begin
                x = longint'($signed(a));
                y = longint'($signed(b));
            end else begin
                x = longint'({32'd0, a});
                y = longint'({32'd0, b});
            end
            q = 32'(x / y);
            r = 32'(x % y);
        end
    endfunction

    // Entered at a negedge with the unit idle; returns at the negedge
    // of the first idle cycle after FINISH.
    task automatic run_div(input logic sgn, input logic [31:0] a,
                           input logic [31:0] b, input logic wr,
                           input logic [31:0] wv, input logic mid);
        int          cyc;
        int          dones;
        logic [31:0] q;
        logic [31:0] r;
        div_start  = 1'b1;
        div_signed = sgn;
        div_a      = a;
        div_b      = b;
        w_hilo     = wr;
        write_hi   = wv;
        write_lo   = wv;
        #1;
        chk("start_stall", stall, 1);
        @(posedge clk);
        #1;
        div_start  = 1'b0;
        div_signed = 1'b0;
        w_hilo     = 1'b0;
        if (wr) begin
            exp_hi = wv;
            exp_lo = wv;
        end
        cyc   = 1;
        dones = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            w_hilo = 1'b0;
            if (!stall) break;
            cyc++;
            dones += int'(div_done);
            chk("busy_hi", hi, exp_hi);
            chk("busy_lo", lo, exp_lo);
            if (mid && cyc == 6) begin
                w_hilo   = 1'b1;
                write_hi = 32'h5555_5555;
                write_lo = 32'h3333_3333;
            end
        end
        model(sgn, a, b, q, r);
        exp_hi = r;
        exp_lo = q;
        chk("stall_cycles", 64'(cyc), 34);
        chk("done_pulses", 64'(dones), 1);
        chk("div_lo", lo, exp_lo);
        chk("div_hi", hi, exp_hi);
    endtask

    task automatic alu_write(input logic [31:0] h, input logic [31:0] l);
        w_hilo   = 1'b1;
        write_hi = h;
        write_lo = l;
        #1;
        chk("wr_stall", stall, 0);
        @(negedge clk);
        w_hilo = 1'b0;
        exp_hi = h;
        exp_lo = l;
        chk("wr_hi", hi, exp_hi);
        chk("wr_lo", lo, exp_lo);
        chk("wr_stall_after", stall, 0);
    endtask

    function automatic logic [31:0] pick(input int k);
        logic [31:0] v;
        v = $urandom;
        case (k)
            0:       v = 32'd0;
            1:       v = 32'hFFFF_FFFF;
            2:       v = 32'h8000_0000;
            3:       v = 32'($urandom_range(1, 15));
            4:       v = {28'hFFFF_FFF, 4'($urandom)};
            default: v = $urandom;
        endcase
        return v;
    endfunction

    initial begin
        total      = 0;
        bad        = 0;
        rst_n      = 1'b0;
        w_hilo     = 1'b0;
        write_hi   = '0;
        write_lo   = '0;
        div_start  = 1'b0;
        div_signed = 1'b0;
        div_a      = '0;
        div_b      = '0;
        exp_hi     = '0;
        exp_lo     = '0;
        repeat (3) @(negedge clk);
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        chk("rst_stall", stall, 0);
        chk("rst_done", div_done, 0);
        rst_n = 1'b1;
        @(negedge clk);

        alu_write(32'h1234_5678, 32'h9ABC_DEF0);
        @(negedge clk);
        chk("hold_hi", hi, 32'h1234_5678);
        chk("hold_lo", lo, 32'h9ABC_DEF0);

        run_div(1'b0, 32'd100, 32'd7, 1'b0, 32'd0, 1'b0);
        chk("divu_100_7_lo", lo, 32'd14);
        chk("divu_100_7_hi", hi, 32'd2);
        run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0, 32'd0, 1'b0);
        chk("div_m7_2_lo", lo, 32'hFFFF_FFFD);
        chk("div_m7_2_hi", hi, 32'hFFFF_FFFF);
        run_div(1'b1, 32'd7, 32'hFFFF_FFFE, 1'b0, 32'd0, 1'b0);
        chk("div_7_m2_lo", lo, 32'hFFFF_FFFD);
        chk("div_7_m2_hi", hi, 32'd1);
        run_div(1'b0, 32'd5, 32'd0, 1'b0, 32'd0, 1'b0);
        chk("divu_5_0_lo", lo, 32'hFFFF_FFFF);
        chk("divu_5_0_hi", hi, 32'd5);
        run_div(1'b1, 32'hFFFF_FFF9, 32'd0, 1'b0, 32'd0, 1'b0);
        chk("div_m7_0_hi", hi, 32'hFFFF_FFF9);
        run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0, 1'b0);
        chk("div_ovf_lo", lo, 32'h8000_0000);
        chk("div_ovf_hi", hi, 32'd0);
        run_div(1'b0, 32'd9, 32'd4, 1'b1, 32'hAAAA_AAAA, 1'b1);
        chk("wr_div_lo", lo, 32'd2);
        chk("wr_div_hi", hi, 32'd1);

        // Abort a division with reset partway through CALC.
        @(negedge clk);
        div_start = 1'b1;
        div_a     = 32'd1000;
        div_b     = 32'd3;
        @(posedge clk);
        #1;
        div_start = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_stall", stall, 0);
        chk("abort_hi", hi, 0);
        chk("abort_lo", lo, 0);
        chk("abort_done", div_done, 0);
        @(negedge clk);
        rst_n  = 1'b1;
        exp_hi = '0;
        exp_lo = '0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            total++;
            if (div_done !== 1'b0) begin
                bad++;
                $display("FAIL abort_no_done got=%b want=0", div_done);
            end
        end
        chk("post_abort_hi", hi, 0);
        run_div(1'b0, 32'd20, 32'd3, 1'b0, 32'd0, 1'b0);
        chk("divu_20_3_lo", lo, 32'd6);
        chk("divu_20_3_hi", hi, 32'd2);

        // Back-to-back and randomised traffic.
        for (int n = 0; n < 40; n++) begin
            logic        sg;
            logic [31:0] a;
            logic [31:0] b;
            sg = 1'($urandom);
            a  = pick(int'($urandom_range(1, 8)));
            b  = pick(int'($urandom_range(0, 9)));
            if ($urandom_range(0, 3) == 0) begin
                alu_write($urandom, $urandom);
            end
            run_div(sg, a, b, ($urandom_range(0, 3) == 0), $urandom,
                    ($urandom_range(0, 3) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
